anim_seq_ctrl: RTL and testbench
================================

Name: anim_seq_ctrl

Overview:
- Parametrised animation sequencer for the 7-segment display designs.
- Debounces a bank of four buttons into single-cycle press pulses.
- Selects one of NUM_ANI animations, with wrap-around in both directions and an optional auto-cycle mode.
- Generates the frame index and frame tick consumed by the segment decoder. The per-animation frame limit comes in from the external limit lookup.

Parameters:
- NUM_ANI, 12: number of animations. ani_sel ranges over 0..NUM_ANI-1.
- ANI_W, 4: width of ani_sel. Must satisfy NUM_ANI <= 2^ANI_W.
- FRAME_W, 5: width of frame and frame_limit.
- CLK_DIV_STEP, 1_000_000: clock cycles per speed step (0.1 s at 10 MHz).
- SPEED_MIN, 1: minimum period_steps.
- SPEED_MAX, 19: maximum period_steps.
- SPEED_RST, 10: period_steps after reset.
- CNT_W, 25: period counter width. Must hold SPEED_MAX*CLK_DIV_STEP.
- DEB_CYCLES, 512: number of stable-high cycles required to register a press.
- DEB_W, 12: debounce counter width. Must hold DEB_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_raw  in  4  raw buttons: [0]=next, [1]=prev, [2]=slower, [3]=faster
- auto_en  in  1  level input; 1 = advance animation automatically at the end of each frame sequence
- frame_limit  in  FRAME_W  last frame index of the current animation
- ani_sel  out  ANI_W  current animation index
- frame  out  FRAME_W  current frame index
- frame_tick  out  1  one-cycle pulse on every frame advance
- period_steps  out  5  current speed setting; frame period = period_steps*CLK_DIV_STEP cycles
- press  out  4  debounced one-cycle press pulses, exported for debug/LEDs

Behaviour:
- All registers update on the rising edge of clk.
- Reset is synchronous and active-high. It overrides everything, including when asserted mid-frame or mid-debounce.
- Reset values: sync flops 0, debounce counters 0, press 0, ani_sel 0, frame 0, period counter 0, frame_tick 0, period_steps SPEED_RST.

Debounce, per button:
- 2-FF synchroniser, then counter.
- Counter increments while the synced input is 1, saturates at DEB_CYCLES, and clears to 0 whenever the synced input is 0.
- press[i] is registered and high for exactly one cycle: the cycle after the counter goes DEB_CYCLES-1 -> DEB_CYCLES.
- Holding the button never produces a second pulse; release and a new stable press are required.
- A glitch shorter than DEB_CYCLES produces no pulse.
- Latency from raw rising edge to the press pulse: DEB_CYCLES+3 cycles.

Animation select:
- press[0]: ani_sel+1, wrapping NUM_ANI-1 -> 0.
- press[1]: ani_sel-1, wrapping 0 -> NUM_ANI-1.
- press[0] and press[1] in the same cycle: no change.
- Auto mode: if auto_en=1 and a frame advance wraps frame to 0, ani_sel advances as for press[0].
- Manual press and auto advance in the same cycle: the manual press is applied and the auto advance is dropped (at most one step per cycle).
- On any ani_sel change, the next cycle has frame=0, period counter=0 and frame_tick=0.

Speed:
- press[2]: period_steps+1, saturating at SPEED_MAX.
- press[3]: period_steps-1, saturating at SPEED_MIN.
- Both pressed in the same cycle: no change.
- A speed change does not reset the period counter.

Frame timing:
- The period counter runs 0..P-1, where P = period_steps*CLK_DIV_STEP computed in CNT_W bits.
- When counter >= P-1:
  - counter <= 0 and frame_tick <= 1 for the next cycle.
  - frame <= 0 if frame >= frame_limit, else frame+1.
- Using >= means a speed-up leaves no stale long period.
- Using >= on frame means a limit that drops below the current frame (animation change) wraps on the next advance.
- frame_limit = 0 holds frame at 0 and still produces ticks.
- In all other cycles frame_tick = 0.

Test Plan:
Bench parameters: CLK_DIV_STEP=4, DEB_CYCLES=4, NUM_ANI=12, SPEED_RST=2, SPEED_MIN=1, SPEED_MAX=3.
1. Reset, then run 24 cycles with frame_limit=2 -> frame_tick every 8 cycles; frame sequence 0,1,2,0; ani_sel=0; period_steps=2.
2. btn_raw[0] high for 3 cycles, then high for 20 cycles -> no pulse for the 3-cycle glitch; exactly one press[0] pulse 7 cycles after the stable edge; ani_sel=1; frame=0 and counter=0 the following cycle.
3. From ani_sel=0, press prev -> ani_sel=11; then press next twice -> ani_sel=1. Next and prev raised on the same cycle -> ani_sel unchanged.
4. Press slower three times from speed 2 -> period_steps 3, 3 (saturates at 3), tick spacing 12 cycles. Press faster three times -> 1, 1, tick spacing 4. Faster pressed at counter=6 with old P=8 -> wrap and tick on the next cycle.
5. auto_en=1, frame_limit=1 -> ani_sel increments every 2 ticks and wraps 11->0. A manual next coinciding with the auto wrap advances ani_sel by exactly 1.
6. Assert reset mid-frame with frame=2, ani_sel=5, speed=3 -> next cycle ani_sel=0, frame=0, frame_tick=0, period_steps=2, press=0.

Source files
------------

// File: rtl/anim_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : anim_seq_ctrl
// Description : Animation sequencer for the 7-segment display designs.
//               Debounces four buttons into one-cycle press pulses, selects
//               the current animation (manual wrap-around or auto-cycle),
//               holds the speed setting and produces the frame index and
//               frame tick consumed by the segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module anim_seq_ctrl #(
    parameter int NUM_ANI      = 12,
    parameter int ANI_W        = 4,
    parameter int FRAME_W      = 5,
    parameter int CLK_DIV_STEP = 1_000_000,
    parameter int SPEED_MIN    = 1,
    parameter int SPEED_MAX    = 19,
    parameter int SPEED_RST    = 10,
    parameter int CNT_W        = 25,
    parameter int DEB_CYCLES   = 512,
    parameter int DEB_W        = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         btn_raw,
    input  logic               auto_en,
    input  logic [FRAME_W-1:0] frame_limit,
    output logic [ANI_W-1:0]   ani_sel,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic [4:0]         period_steps,
    output logic [3:0]         press
);

    localparam logic [DEB_W-1:0] c_deb_full   = DEB_W'(DEB_CYCLES);
    localparam logic [ANI_W-1:0] c_ani_last   = ANI_W'(NUM_ANI - 1);
    localparam logic [CNT_W-1:0] c_div_step   = CNT_W'(CLK_DIV_STEP);
    localparam logic [4:0]       c_speed_min  = 5'(SPEED_MIN);
    localparam logic [4:0]       c_speed_max  = 5'(SPEED_MAX);
    localparam logic [4:0]       c_speed_rst  = 5'(SPEED_RST);

    // ------------------------------------------------------------------
    // Button synchronisation and debounce
    // ------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic [DEB_W-1:0] r_deb_cnt;
            logic             r_deb_full;
            logic             r_press;

            // Saturating stable-high counter; the press fires once, on the
            // first cycle the counter is seen full (r_deb_full still low)
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_deb_cnt  <= '0;
                    r_deb_full <= 1'b0;
                    r_press    <= 1'b0;
                end else begin
                    if (!r_sync2[gi]) begin
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt != c_deb_full) begin
                        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                    end
                    r_deb_full <= (r_deb_cnt == c_deb_full);
                    r_press    <= (r_deb_cnt == c_deb_full) && !r_deb_full;
                end
            end

            assign press[gi] = r_press;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Animation select and frame timing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_period_last;
    logic             w_cnt_wrap;
    logic             w_frame_end;
    logic             w_next_req;
    logic             w_prev_req;
    logic             w_manual_any;
    logic             w_auto_adv;
    logic             w_ani_change;
    logic [ANI_W-1:0] w_ani_inc;
    logic [ANI_W-1:0] w_ani_dec;

    assign w_period      = {{(CNT_W-5){1'b0}}, period_steps} * c_div_step;
    assign w_period_last = w_period - CNT_W'(1);

    // >= so that a shortened period or a lowered frame limit wraps at once
    assign w_cnt_wrap    = (r_cnt >= w_period_last);
    assign w_frame_end   = (frame >= frame_limit);

    // Opposite presses cancel; any manual press suppresses the auto step
    assign w_next_req    = press[0] & ~press[1];
    assign w_prev_req    = press[1] & ~press[0];
    assign w_manual_any  = press[0] | press[1];
    assign w_auto_adv    = auto_en & w_cnt_wrap & w_frame_end & ~w_manual_any;
    assign w_ani_change  = w_next_req | w_prev_req | w_auto_adv;

    assign w_ani_inc = (ani_sel == c_ani_last) ? '0 : ani_sel + ANI_W'(1);
    assign w_ani_dec = (ani_sel == '0) ? c_ani_last : ani_sel - ANI_W'(1);

    // Animation change restarts the sequence; otherwise the period counter
    // advances the frame and emits a one-cycle tick on each wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            ani_sel    <= '0;
            frame      <= '0;
            r_cnt      <= '0;
            frame_tick <= 1'b0;
        end else if (w_ani_change) begin
            ani_sel    <= w_prev_req ? w_ani_dec : w_ani_inc;
            frame      <= '0;
            r_cnt      <= '0;
            frame_tick <= 1'b0;
        end else if (w_cnt_wrap) begin
            r_cnt      <= '0;
            frame_tick <= 1'b1;
            frame      <= w_frame_end ? '0 : frame + FRAME_W'(1);
        end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
            frame_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Speed setting
    // ------------------------------------------------------------------

    // Saturating speed steps; the period counter keeps running across changes
    always_ff @(posedge clk) begin
        if (reset) begin
            period_steps <= c_speed_rst;
        end else if (press[2] && !press[3]) begin
            if (period_steps < c_speed_max) begin
                period_steps <= period_steps + 5'd1;
            end
        end else if (press[3] && !press[2]) begin
            if (period_steps > c_speed_min) begin
                period_steps <= period_steps - 5'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_anim_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_anim_seq_ctrl
// Description : Self-checking bench for anim_seq_ctrl with a cycle model
//               built from press-window and modular-arithmetic rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anim_seq_ctrl;

    localparam int NA   = 12;
    localparam int DIV  = 4;
    localparam int DEB  = 4;
    localparam int SMIN = 1;
    localparam int SMAX = 3;
    localparam int SRST = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       auto_en = 1'b0;
    logic [4:0] frame_limit = 5'd2;
    logic [3:0] ani_sel;
    logic [4:0] frame;
    logic       frame_tick;
    logic [4:0] period_steps;
    logic [3:0] press;

    always #5 clk = ~clk;

    anim_seq_ctrl #(
        .NUM_ANI(NA), .ANI_W(4), .FRAME_W(5), .CLK_DIV_STEP(DIV),
        .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .SPEED_RST(SRST),
        .CNT_W(25), .DEB_CYCLES(DEB), .DEB_W(12)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .auto_en(auto_en),
        .frame_limit(frame_limit), .ani_sel(ani_sel), .frame(frame),
        .frame_tick(frame_tick), .period_steps(period_steps), .press(press)
    );

    int checks = 0;
    int failures = 0;
    int pcnt [4];

    // Reference model state
    logic [3:0] m_hist [0:DEB+3];
    logic [3:0] m_press;
    int m_ani, m_frame, m_cnt, m_tick, m_steps;

    typedef struct {
        logic [3:0] btn;
        logic       au;
        int         lim;
        int         ncyc;
        int         e_ani;
        int         e_frame;
        int         e_tick;
        int         e_steps;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A press appears once a button has been sampled high on DEB consecutive
    // edges, two edges of synchroniser delay earlier, after a low sample.
    task automatic model_edge();
        logic [3:0] op;
        bit nx, pv, man, wrap, fend, chg;
        if (reset) begin
            for (int j = 0; j <= DEB + 3; j++) m_hist[j] = 4'b0000;
            m_press = 4'b0000;
            m_ani = 0; m_frame = 0; m_cnt = 0; m_tick = 0; m_steps = SRST;
            return;
        end
        op = m_press;
        for (int j = DEB + 3; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = btn_raw;
        for (int b = 0; b < 4; b++) begin
            bit run;
            run = 1'b1;
            for (int j = 3; j <= DEB + 2; j++) if (!m_hist[j][b]) run = 1'b0;
            m_press[b] = run && !m_hist[DEB+3][b];
        end
        nx   = op[0] && !op[1];
        pv   = op[1] && !op[0];
        man  = op[0] || op[1];
        wrap = (m_cnt >= m_steps * DIV - 1);
        fend = (m_frame >= int'(frame_limit));
        chg  = 1'b1;
        if (nx)                              m_ani = (m_ani + 1) % NA;
        else if (pv)                         m_ani = (m_ani + NA - 1) % NA;
        else if (!man && auto_en && wrap && fend) m_ani = (m_ani + 1) % NA;
        else                                 chg = 1'b0;
        if (chg) begin
            m_frame = 0; m_cnt = 0; m_tick = 0;
        end else if (wrap) begin
            m_cnt = 0; m_tick = 1;
            m_frame = fend ? 0 : m_frame + 1;
        end else begin
            m_cnt++; m_tick = 0;
        end
        if (op[2] && !op[3])      m_steps = (m_steps + 1 > SMAX) ? SMAX : m_steps + 1;
        else if (op[3] && !op[2]) m_steps = (m_steps - 1 < SMIN) ? SMIN : m_steps - 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("ani_sel", int'(ani_sel), m_ani);
        chk("frame", int'(frame), m_frame);
        chk("frame_tick", int'(frame_tick), m_tick);
        chk("period_steps", int'(period_steps), m_steps);
        chk("press", int'(press), int'(m_press));
        for (int b = 0; b < 4; b++) pcnt[b] += int'(press[b]);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic press_btn(input int b);
        btn_raw[b] = 1'b1;
        run(DEB + 4);
        btn_raw[b] = 1'b0;
        run(3);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        cyc(); n++;
        while (!frame_tick && n < 40) begin
            cyc(); n++;
        end
        chk("tick_within_budget", int'(frame_tick), 1);
    endtask

    initial begin
        int n, k, old, prev;
        bit wrap_seen;
        logic [3:0] rb;

        for (int b = 0; b < 4; b++) pcnt[b] = 0;

        // Test 1 vectors: frame_tick every 8 cycles, frames 0,1,2,0
        tbl[0] = '{4'b0000, 1'b0, 2, 7, 0, 0, 0, 2};
        tbl[1] = '{4'b0000, 1'b0, 2, 1, 0, 1, 1, 2};
        tbl[2] = '{4'b0000, 1'b0, 2, 8, 0, 2, 1, 2};
        tbl[3] = '{4'b0000, 1'b0, 2, 8, 0, 0, 1, 2};

        #1;
        reset = 1'b1;
        run(2);
        chk("rst_ani", int'(ani_sel), 0);
        chk("rst_frame", int'(frame), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_steps", int'(period_steps), 2);
        chk("rst_press", int'(press), 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            btn_raw     = tbl[i].btn;
            auto_en     = tbl[i].au;
            frame_limit = 5'(tbl[i].lim);
            run(tbl[i].ncyc);
            chk("tbl_ani", int'(ani_sel), tbl[i].e_ani);
            chk("tbl_frame", int'(frame), tbl[i].e_frame);
            chk("tbl_tick", int'(frame_tick), tbl[i].e_tick);
            chk("tbl_steps", int'(period_steps), tbl[i].e_steps);
        end

        // Test 2: glitch rejected, then one stable press with latency 7
        btn_raw[0] = 1'b1;
        run(3);
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("glitch_no_press", int'(press[0]), 0);
        end
        pcnt[0] = 0;
        btn_raw[0] = 1'b1;
        k = 0;
        while (k < 20 && !press[0]) begin
            cyc(); k++;
        end
        chk("press_latency", k, DEB + 3);
        cyc();
        chk("chg_ani", int'(ani_sel), 1);
        chk("chg_frame", int'(frame), 0);
        chk("chg_tick", int'(frame_tick), 0);
        wait_tick(n);
        chk("tick_after_change", n, 8);
        run(6);
        chk("single_pulse", pcnt[0], 1);
        btn_raw[0] = 1'b0;
        run(3);

        // Test 3: wrap in both directions, simultaneous presses cancel
        press_btn(1);
        chk("prev_to_0", int'(ani_sel), 0);
        press_btn(1);
        chk("prev_wrap", int'(ani_sel), 11);
        press_btn(0);
        chk("next_wrap", int'(ani_sel), 0);
        press_btn(0);
        chk("next_to_1", int'(ani_sel), 1);
        btn_raw[1:0] = 2'b11;
        run(DEB + 4);
        btn_raw[1:0] = 2'b00;
        run(3);
        chk("both_no_change", int'(ani_sel), 1);

        // Test 4: speed saturation and tick spacing
        press_btn(2);
        chk("slower1", int'(period_steps), 3);
        press_btn(2);
        chk("slower2", int'(period_steps), 3);
        press_btn(2);
        chk("slower3", int'(period_steps), 3);
        wait_tick(n);
        wait_tick(n);
        chk("spacing_slow", n, 12);
        press_btn(3);
        chk("faster1", int'(period_steps), 2);
        press_btn(3);
        chk("faster2", int'(period_steps), 1);
        press_btn(3);
        chk("faster3", int'(period_steps), 1);
        wait_tick(n);
        wait_tick(n);
        chk("spacing_fast", n, 4);
        press_btn(2);
        chk("back_to_2", int'(period_steps), 2);
        wait_tick(n);
        run(7);
        btn_raw[3] = 1'b1;
        run(7);
        chk("faster_at_cnt6", int'(press[3]), 1);
        cyc();
        chk("faster_applied", int'(period_steps), 1);
        chk("no_tick_yet", int'(frame_tick), 0);
        cyc();
        chk("tick_after_speedup", int'(frame_tick), 1);
        btn_raw[3] = 1'b0;
        wait_tick(n);
        chk("spacing_after_speedup", n, 4);

        // Test 5: auto-cycle with wrap, then manual press coinciding
        auto_en = 1'b1;
        frame_limit = 5'd1;
        prev = int'(ani_sel);
        wrap_seen = 1'b0;
        for (int i = 0; i < 130; i++) begin
            cyc();
            if (int'(ani_sel) != prev) begin
                chk("auto_step", int'(ani_sel), (prev + 1) % NA);
                if (prev == NA - 1 && ani_sel == 4'd0) wrap_seen = 1'b1;
                prev = int'(ani_sel);
            end
        end
        chk("auto_wrap_seen", int'(wrap_seen), 1);
        old = int'(ani_sel);
        k = 0;
        while (int'(ani_sel) == old && k < 20) begin
            cyc(); k++;
        end
        chk("auto_change_within_budget", int'(int'(ani_sel) != old), 1);
        old = int'(ani_sel);
        btn_raw[0] = 1'b1;
        run(7);
        chk("pre_coincide", int'(ani_sel), old);
        cyc();
        chk("coincide_single_step", int'(ani_sel), (old + 1) % NA);
        btn_raw[0] = 1'b0;
        auto_en = 1'b0;
        run(3);

        // Test 6: reset mid-frame and mid-debounce
        k = 0;
        while (m_ani != 5 && k < NA) begin
            press_btn(0); k++;
        end
        press_btn(2);
        press_btn(2);
        frame_limit = 5'd3;
        k = 0;
        while (!(m_frame == 2 && m_cnt == 2) && k < 300) begin
            cyc(); k++;
        end
        chk("reach_frame2", int'(frame), 2);
        btn_raw[1] = 1'b1;
        run(2);
        chk("pre_rst_ani", int'(ani_sel), 5);
        chk("pre_rst_steps", int'(period_steps), 3);
        chk("pre_rst_frame", int'(frame), 2);
        reset = 1'b1;
        cyc();
        chk("mid_rst_ani", int'(ani_sel), 0);
        chk("mid_rst_frame", int'(frame), 0);
        chk("mid_rst_tick", int'(frame_tick), 0);
        chk("mid_rst_steps", int'(period_steps), 2);
        chk("mid_rst_press", int'(press), 0);
        reset = 1'b0;
        run(10);
        btn_raw = 4'b0000;
        run(4);

        // Randomised phase against the model
        rb = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) rb[b] = ~rb[b];
            btn_raw = rb;
            if ($urandom_range(0, 49) == 0) frame_limit = 5'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
            reset = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
